// File: rtl/uart_tx_if.sv
// Parallel-side handshake between the UART interface block and the serial transmitter.
interface uart_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_en;
  logic                  tx_done;
  logic                  tx_busy;
  logic                  tx;

  // Requester side: drives the byte and the send strobe, observes status and line.
  modport master (
    output tx_data,
    output tx_en,
    input  tx_done,
    input  tx_busy,
    input  tx
  );

  // Transmitter side.
  modport slave (
    input  tx_data,
    input  tx_en,
    output tx_done,
    output tx_busy,
    output tx
  );

endinterface

// File: rtl/uart_tx.sv
// UART serial transmitter: start / LSB-first data / optional parity / stop frame,
// bit timing from a per-bit cycle counter on the system clock.
module uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BPS          = 115_200,
  parameter int unsigned SYS_CLK_FREQ = 50_000_000,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus
);

  localparam int unsigned CPB   = SYS_CLK_FREQ / BPS;
  localparam int unsigned CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned BIT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  // Reject configurations the frame timing cannot represent.
  if (CPB < 2) begin : g_bad_cpb
    $error("uart_tx: SYS_CLK_FREQ/BPS must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("uart_tx: DATA_WIDTH must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cyc_q;
  logic [BIT_W-1:0]      bit_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  cyc_last;

  // End of the current bit period.
  assign cyc_last = (cyc_q == CNT_W'(CPB - 1));

  // Frame sequencer; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cyc_q  <= '0;
          bit_q  <= '0;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (bus.tx_en) begin
            shift_q <= bus.tx_data;
            par_q   <= (^bus.tx_data) ^ (PARITY_ODD != 0);
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end

        START: begin
          if (cyc_last) begin
            cyc_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            cyc_q <= cyc_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (cyc_last) begin
            cyc_q   <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
              bit_q <= '0;
              if (PARITY_EN != 0) begin
                tx_q    <= par_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              bit_q <= bit_q + BIT_W'(1);
              tx_q  <= shift_q[1];
            end
          end else begin
            cyc_q <= cyc_q + CNT_W'(1);
          end
        end

        PARITY: begin
          if (cyc_last) begin
            cyc_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            cyc_q <= cyc_q + CNT_W'(1);
          end
        end

        STOP: begin
          tx_q <= 1'b1;
          if (cyc_last) begin
            cyc_q <= '0;
            if (bit_q == BIT_W'(STOP_BITS - 1)) begin
              bit_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end else begin
            cyc_q <= cyc_q + CNT_W'(1);
            // Raise done so it coincides with the final cycle of the last stop bit.
            if (cyc_q == CNT_W'(CPB - 2) && bit_q == BIT_W'(STOP_BITS - 1)) begin
              done_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          cyc_q   <= '0;
          bit_q   <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule
